// File: rtl/rd0_burst_ctrl.sv
// Read-side DMA burst scheduler for the rd0 display path: walks one frame of DDR
// in fixed-length bursts, gated on rd0 FIFO headroom, one burst outstanding at a time.
module rd0_burst_ctrl #(
  parameter int ADDR_WIDTH       = 28,
  parameter int FIFO_DEPTH_WIDTH = 9,
  parameter int BURST_LEN        = 64,
  parameter int FRAME_BEATS      = 230400,
  parameter int SETTLE_CYC       = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic [ADDR_WIDTH-1:0]       frame_base,
  input  logic [FIFO_DEPTH_WIDTH:0]   fifo_water_level,
  output logic                        ddr_rd_req,
  output logic [ADDR_WIDTH-1:0]       ddr_rd_addr,
  output logic [7:0]                  ddr_rd_len,
  input  logic                        ddr_rd_ack,
  input  logic                        ddr_rd_data_valid,
  input  logic                        ddr_rd_last,
  output logic                        fifo_wr_en,
  output logic                        busy,
  output logic                        frame_done,
  output logic [1:0]                  err
);

  localparam int FRAME_BURSTS = FRAME_BEATS / BURST_LEN;
  localparam int BL_W         = $clog2(FRAME_BURSTS + 1);
  localparam int BEAT_W       = $clog2(BURST_LEN) + 2;
  localparam int SET_W        = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [FIFO_DEPTH_WIDTH:0] LEVEL_MAX =
    (FIFO_DEPTH_WIDTH+1)'((2 ** FIFO_DEPTH_WIDTH) - BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES    = ADDR_WIDTH'(BURST_LEN * 8);
  localparam logic [BL_W-1:0]       FRAME_BURSTS_L = BL_W'(FRAME_BURSTS);
  localparam logic [BEAT_W-1:0]     BURST_LEN_L    = BEAT_W'(BURST_LEN);
  localparam logic [SET_W-1:0]      SETTLE_LAST    = SET_W'(SETTLE_CYC - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BL_W-1:0]       bursts_left;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [SET_W-1:0]      settle_cnt;
  logic                  restart_pend;
  logic [ADDR_WIDTH-1:0] restart_base;

  logic              in_data;
  logic              beat_now;
  logic              burst_end;
  logic              short_burst;
  logic              stray_beat;
  logic [BEAT_W-1:0] beat_next;

  assign in_data     = (state == S_DATA);
  assign beat_now    = in_data && ddr_rd_data_valid;
  assign burst_end   = beat_now && ddr_rd_last;
  assign beat_next   = beat_cnt + BEAT_W'(1);
  assign short_burst = burst_end && (beat_next != BURST_LEN_L);
  assign stray_beat  = ddr_rd_data_valid && !in_data;

  assign busy        = (state != S_IDLE);
  assign ddr_rd_req  = (state == S_REQ);
  assign ddr_rd_addr = addr;
  assign ddr_rd_len  = 8'(BURST_LEN - 1);
  // Beats outside DATA are dropped here so the FIFO never sees them.
  assign fifo_wr_en  = beat_now;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      addr         <= '0;
      bursts_left  <= '0;
      beat_cnt     <= '0;
      settle_cnt   <= '0;
      restart_pend <= 1'b0;
      restart_base <= '0;
      frame_done   <= 1'b0;
      err          <= 2'b00;
    end else begin
      frame_done <= 1'b0;
      err        <= {stray_beat || short_burst, frame_start && busy};

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            addr        <= frame_base;
            bursts_left <= FRAME_BURSTS_L;
            state       <= S_CHECK;
          end
        end

        S_CHECK, S_SETTLE: begin
          if (frame_start) begin
            addr        <= frame_base;
            bursts_left <= FRAME_BURSTS_L;
            state       <= S_CHECK;
          end else if (state == S_CHECK) begin
            if (fifo_water_level <= LEVEL_MAX) state <= S_REQ;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end

        S_REQ: begin
          if (frame_start) begin
            restart_pend <= 1'b1;
            restart_base <= frame_base;
          end
          if (ddr_rd_ack) begin
            beat_cnt <= '0;
            state    <= S_DATA;
          end
        end

        S_DATA: begin
          if (frame_start) begin
            restart_pend <= 1'b1;
            restart_base <= frame_base;
          end
          if (beat_now && !(&beat_cnt)) beat_cnt <= beat_next;
          // A short burst still consumes a full burst of address space.
          if (burst_end) begin
            if (restart_pend || frame_start) begin
              addr         <= frame_start ? frame_base : restart_base;
              bursts_left  <= FRAME_BURSTS_L;
              restart_pend <= 1'b0;
              state        <= S_CHECK;
            end else begin
              addr        <= addr + BURST_BYTES;
              bursts_left <= bursts_left - BL_W'(1);
              settle_cnt  <= '0;
              if (bursts_left == BL_W'(1)) begin
                frame_done <= 1'b1;
                state      <= S_IDLE;
              end else begin
                state <= (SETTLE_CYC == 0) ? S_CHECK : S_SETTLE;
              end
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rd0_burst_ctrl.sv
// Randomized scoreboard bench for rd0_burst_ctrl: a DDR responder drives bursts, a
// frame-level model predicts request addresses, FIFO writes and pulse outputs.
module tb_rd0_burst_ctrl;

  localparam int AW = 28;
  localparam int DW = 9;
  localparam int BL = 64;
  localparam int FB = 256;
  localparam int NB = FB / BL;
  localparam int LVL_MAX = (1 << DW) - BL;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic [AW-1:0] frame_base;
  logic [DW:0]   level;
  logic          req;
  logic [AW-1:0] addr;
  logic [7:0]    len;
  logic          ack;
  logic          dv;
  logic          last;
  logic          wr_en;
  logic          busy;
  logic          frame_done;
  logic [1:0]    err;

  rd0_burst_ctrl #(
    .ADDR_WIDTH(AW), .FIFO_DEPTH_WIDTH(DW), .BURST_LEN(BL),
    .FRAME_BEATS(FB), .SETTLE_CYC(2)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_base(frame_base),
    .fifo_water_level(level), .ddr_rd_req(req), .ddr_rd_addr(addr), .ddr_rd_len(len),
    .ddr_rd_ack(ack), .ddr_rd_data_valid(dv), .ddr_rd_last(last),
    .fifo_wr_en(wr_en), .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard: expected request addresses, per-valid write enables, and
  // pulse events {frame_done, err[1], err[0]} keyed by the cycle they must appear in.
  logic [AW-1:0] exp_addr_q[$];
  bit            exp_wr_q[$];
  logic [2:0]    exp_ev[int];

  // Frame-level model state.
  bit frame_active_m = 0;
  bit in_burst_m     = 0;
  bit pend_m         = 0;
  int bursts_left_m  = 0;
  int wr_seen        = 0;

  task automatic expect_ev(input int c, input logic [2:0] v);
    if (exp_ev.exists(c)) exp_ev[c] = exp_ev[c] | v;
    else exp_ev[c] = v;
  endtask

  task automatic start_frame(input logic [AW-1:0] base);
    logic [AW-1:0] a;
    frame_start = 1'b1;
    frame_base  = base;
    if (frame_active_m) begin
      expect_ev(cyc + 1, 3'b001);
      if (in_burst_m) pend_m = 1;
    end
    frame_active_m = 1;
    bursts_left_m  = NB;
    exp_addr_q.delete();
    for (int i = 0; i < NB; i++) begin
      a = base + AW'(i * BL * 8);
      exp_addr_q.push_back(a);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    ack         = 1'b0;
    dv          = 1'b0;
    last        = 1'b0;
  endtask

  task automatic send_beat(input bit is_last, input bit legit);
    dv   = 1'b1;
    last = is_last;
    exp_wr_q.push_back(legit);
    if (!legit) expect_ev(cyc + 1, 3'b010);
  endtask

  task automatic rand_level();
    if ($urandom_range(0, 1) != 0) level = 10'($urandom_range(0, LVL_MAX));
    else level = 10'($urandom_range(LVL_MAX + 1, 1 << DW));
  endtask

  // One burst from the DDR side: wait for the request, optionally withhold ack,
  // then return beats with random gaps. Returns in the cycle of the final beat
  // (or of the stray beat, if requested).
  task automatic do_burst(input int short_at, input int overrun_at, input logic [AW-1:0] ov_base,
                          input bit stray_after, input bit rnd_lvl, input int ack_dly);
    int t = 0;
    int n;
    int k = 0;
    int d;
    while (!req && t < 300) begin
      tick();
      if (rnd_lvl) rand_level();
      t++;
    end
    if (!req) begin
      check("req_timeout", req, 1'b1);
      frame_active_m = 0;
      return;
    end
    d = (ack_dly < 0) ? $urandom_range(0, 4) : ack_dly;
    for (int i = 0; i < d; i++) begin
      tick();
      check("req_held", req, 1'b1);
    end
    ack = 1'b1;
    in_burst_m = 1;
    n = (short_at > 0) ? short_at : BL;
    while (k < n) begin
      tick();
      if ($urandom_range(0, 3) != 0) begin
        k++;
        send_beat(k == n, 1'b1);
        if (k == overrun_at) start_frame(ov_base);
      end
    end
    in_burst_m = 0;
    if (short_at > 0) expect_ev(cyc + 1, 3'b010);
    if (pend_m) pend_m = 0;
    else begin
      bursts_left_m--;
      if (bursts_left_m == 0) begin
        expect_ev(cyc + 1, 3'b100);
        frame_active_m = 0;
      end
    end
    if (stray_after) begin
      tick();
      send_beat(1'b0, 1'b0);
    end
  endtask

  task automatic run_to_end(input bit rnd);
    int nb = 0;
    while (frame_active_m && nb < 40) begin
      if (rnd)
        do_burst(($urandom_range(0, 9) == 0) ? $urandom_range(1, BL - 1) : 0,
                 ($urandom_range(0, 6) == 0) ? $urandom_range(1, BL - 2) : 0,
                 AW'($urandom), $urandom_range(0, 4) == 0, 1'b1, -1);
      else
        do_burst(0, 0, '0, 1'b0, 1'b0, -1);
      nb++;
    end
  endtask

  // Monitor: compares every DUT presentation against the scoreboard.
  logic [2:0]  obs;
  logic        prev_req = 1'b0;
  logic        prev_acc = 1'b0;
  logic [DW:0] prev_level = '0;

  always @(negedge clk) begin
    obs = {frame_done, err};
    if (exp_ev.exists(cyc)) begin
      check("pulse_event", obs, exp_ev[cyc]);
      exp_ev.delete(cyc);
    end else if (obs !== 3'b000) begin
      check("unexpected_pulse", obs, 3'b000);
    end

    if (dv) begin
      if (exp_wr_q.size() > 0) check("fifo_wr_en", wr_en, exp_wr_q.pop_front());
      else check("fifo_wr_en_unplanned", wr_en, 1'b0);
    end else if (wr_en === 1'b1) begin
      check("fifo_wr_en_without_valid", wr_en, 1'b0);
    end
    if (wr_en === 1'b1) wr_seen++;

    if (req === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        check("req_unexpected", req, 1'b0);
      end else begin
        check("req_addr", addr, exp_addr_q[0]);
        check("req_len", len, BL - 1);
        if (!prev_req) check("req_level_ok", prev_level <= LVL_MAX, 1'b1);
        if (ack) void'(exp_addr_q.pop_front());
      end
    end
    if (prev_acc) check("req_drop_after_ack", req, 1'b0);
    prev_acc   = req && ack;
    prev_req   = req;
    prev_level = level;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int w0;
  int t;

  initial begin
    rst = 1'b1; frame_start = 1'b0; frame_base = '0; level = '0;
    ack = 1'b0; dv = 1'b0; last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_req", req, 1'b0);
    check("rst_addr", addr, '0);
    check("rst_len", len, BL - 1);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_pulses", {frame_done, err}, 3'b000);

    // Basic frame with an empty FIFO, including the 2-cycle request latency.
    w0 = wr_seen;
    start_frame(28'h0100000);
    tick();
    check("t1_req_latency_1", req, 1'b0);
    tick();
    check("t1_req_latency_2", req, 1'b1);
    run_to_end(1'b0);
    repeat (3) tick();
    check("t1_writes", wr_seen - w0, 256);
    check("t1_idle", busy, 1'b0);

    // Water level just above the limit blocks, one lower releases; then ack withheld 5 cycles.
    level = 10'(LVL_MAX + 1);
    start_frame(28'h0ABC000);
    repeat (10) tick();
    check("t2_blocked", req, 1'b0);
    level = 10'(LVL_MAX);
    tick();
    check("t2_released", req, 1'b1);
    do_burst(0, 0, '0, 1'b0, 1'b0, 5);
    run_to_end(1'b0);
    repeat (3) tick();

    // Overrun during beat 20 of the second burst.
    w0 = wr_seen;
    start_frame(28'h0300000);
    do_burst(0, 0, '0, 1'b0, 1'b0, -1);
    do_burst(0, 20, 28'h0200000, 1'b0, 1'b0, -1);
    run_to_end(1'b0);
    repeat (3) tick();
    check("t4_writes", wr_seen - w0, 2 * BL + FB);

    // Short burst then a stray beat in SETTLE.
    w0 = wr_seen;
    start_frame(28'h0400000);
    do_burst(10, 0, '0, 1'b1, 1'b0, -1);
    run_to_end(1'b0);
    repeat (3) tick();
    check("t5_writes", wr_seen - w0, 10 + (NB - 1) * BL);

    // Overrun while stalled in CHECK.
    level = 10'(LVL_MAX + 50);
    start_frame(28'h0500000);
    repeat (4) tick();
    start_frame(28'h0600000);
    tick();
    level = '0;
    run_to_end(1'b0);

    // Address wrap, then a new frame_start in the frame_done cycle.
    tick();
    start_frame(28'hFFFFE00);
    run_to_end(1'b0);
    tick();
    start_frame(28'h0700000);
    run_to_end(1'b0);

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(1, 6)) tick();
      start_frame(AW'($urandom));
      run_to_end(1'b1);
    end
    repeat (4) tick();
    level = '0;

    // Reset in the middle of a burst.
    start_frame(28'h0800000);
    t = 0;
    while (!req && t < 50) begin
      tick();
      t++;
    end
    check("t6_req_seen", req, 1'b1);
    ack = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      send_beat(1'b0, 1'b1);
    end
    tick();
    rst = 1'b1;
    exp_addr_q.delete();
    exp_ev.delete();
    frame_active_m = 0;
    pend_m = 0;
    in_burst_m = 0;
    tick();
    rst = 1'b0;
    check("t6_busy", busy, 1'b0);
    check("t6_req", req, 1'b0);
    check("t6_addr", addr, '0);
    check("t6_pulses", {frame_done, err}, 3'b000);
    w0 = wr_seen;
    for (int i = 0; i < 5; i++) begin
      tick();
      send_beat(i == 4, 1'b0);
    end
    repeat (3) tick();
    check("t6_no_writes", wr_seen - w0, 0);

    // Controller is usable again after reset.
    start_frame(28'h0900000);
    run_to_end(1'b0);
    repeat (5) tick();
    check("final_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
